// File: rtl/timer_pkg.sv
// Shared types for the timer bank: command opcodes, channel modes and the
// channel-index width helper used to size the cmd_ch / rd_ch ports.
// Pure declarations, no logic, no state.
package timer_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  // Channel-index width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period/mode/count registers, running/pending/overflow.
// Latency: commands act on the sampling edge; overflow registered (1 cycle).
// Backpressure: none, every decoded command is accepted.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   tick                  shared prescaler tick
//   start, stop, clear    decoded one-hot commands for this channel
//   start_mode/period     mode and terminal count loaded by start
//   count                 current counter value
//   running               channel active
//   pending               sticky wrap flag, cleared by clear
//   overflow              one-cycle pulse after a wrap edge
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  mode_t            start_mode,
  input  logic [WIDTH-1:0] start_period,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             pending,
  output logic             overflow
);

  logic [WIDTH-1:0] period_q;
  mode_t            mode_q;
  logic             wrap;

  // START and STOP both pre-empt a wrap on the same edge.
  assign wrap = tick && running && (count == period_q) && !start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      mode_q   <= MODE_PERIODIC;
      count    <= '0;
      running  <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= wrap;

      if (start) begin
        period_q <= start_period;
        mode_q   <= start_mode;
        count    <= '0;
        running  <= 1'b1;
      end else if (stop) begin
        running  <= 1'b0;
      end else if (tick && running) begin
        if (count == period_q) begin
          count <= '0;
          if (mode_q == MODE_ONESHOT) running <= 1'b0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end

      // A wrap on the same edge as a clear keeps the flag set.
      if (wrap)       pending <= 1'b1;
      else if (clear) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel interval timer: shared prescaler, NUM_CH channels, readback, irq.
// Latency: commands act on the sampling edge; rd_count/overflow 1 cycle, irq 2.
// Backpressure: none, cmd_valid is accepted every cycle; bad channels ignored.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cmd_valid/ch/op     command strobe, target channel, opcode
//   cmd_mode/period     START parameters
//   rd_ch, rd_count     readback channel select and registered count
//   overflow, pending   per-channel wrap pulse and sticky flag
//   running             per-channel active flag
//   irq                 registered OR of pending
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  input  logic [ch_w(NUM_CH)-1:0]   cmd_ch,
  input  op_t                       cmd_op,
  input  mode_t                     cmd_mode,
  input  logic [WIDTH-1:0]          cmd_period,
  input  logic [ch_w(NUM_CH)-1:0]   rd_ch,
  output logic [WIDTH-1:0]          rd_count,
  output logic [NUM_CH-1:0]         overflow,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         running,
  output logic                      irq
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int PW   = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  // Free-running prescaler; never realigned by commands.
  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(PRESCALE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  logic [WIDTH-1:0] ch_count [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    // Indices >= NUM_CH match no instance and so are dropped here.
    assign hit = cmd_valid && (cmd_ch == CH_W'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .start        (hit && (cmd_op == OP_START)),
      .stop         (hit && (cmd_op == OP_STOP)),
      .clear        (hit && (cmd_op == OP_CLEAR)),
      .start_mode   (cmd_mode),
      .start_period (cmd_period),
      .count        (ch_count[i]),
      .running      (running[i]),
      .pending      (pending[i]),
      .overflow     (overflow[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      irq      <= 1'b0;
    end else begin
      rd_count <= (int'(rd_ch) < NUM_CH) ? ch_count[rd_ch] : '0;
      irq      <= |pending;
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;
  import timer_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // PRESCALE=0 instance
  logic         cmd_valid;
  logic [0:0]   cmd_ch;
  op_t          cmd_op;
  mode_t        cmd_mode;
  logic [W-1:0] cmd_period;
  logic [0:0]   rd_ch;
  logic [W-1:0] rd_count;
  logic [1:0]   overflow, pending, running;
  logic         irq;

  // PRESCALE=3 instance
  logic         p3_cmd_valid;
  logic [0:0]   p3_cmd_ch;
  op_t          p3_cmd_op;
  mode_t        p3_cmd_mode;
  logic [W-1:0] p3_cmd_period;
  logic [0:0]   p3_rd_ch;
  logic [W-1:0] p3_rd_count;
  logic [1:0]   p3_overflow, p3_pending, p3_running;
  logic         p3_irq;

  timer_bank #(.NUM_CH(2), .WIDTH(W), .PRESCALE(0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_period(cmd_period), .rd_ch(rd_ch), .rd_count(rd_count),
    .overflow(overflow), .pending(pending), .running(running), .irq(irq)
  );

  timer_bank #(.NUM_CH(2), .WIDTH(W), .PRESCALE(3)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(p3_cmd_valid), .cmd_ch(p3_cmd_ch), .cmd_op(p3_cmd_op),
    .cmd_mode(p3_cmd_mode), .cmd_period(p3_cmd_period), .rd_ch(p3_rd_ch), .rd_count(p3_rd_count),
    .overflow(p3_overflow), .pending(p3_pending), .running(p3_running), .irq(p3_irq)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the next posedge samples the command.
  task automatic cmd(input logic [0:0] ch, input op_t op, input mode_t mode, input logic [W-1:0] per);
    cmd_valid  = 1'b1;
    cmd_ch     = ch;
    cmd_op     = op;
    cmd_mode   = mode;
    cmd_period = per;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idle_hits;
    int pulses [8];
    int np;

    cmd_valid = 1'b0; cmd_ch = '0; cmd_op = OP_NOP; cmd_mode = MODE_PERIODIC;
    cmd_period = '0; rd_ch = '0;
    p3_cmd_valid = 1'b0; p3_cmd_ch = '0; p3_cmd_op = OP_NOP; p3_cmd_mode = MODE_PERIODIC;
    p3_cmd_period = '0; p3_rd_ch = '0;

    // Reset state
    cyc(2);
    chk("rst_overflow", overflow, 0);
    chk("rst_pending",  pending,  0);
    chk("rst_running",  running,  0);
    chk("rst_irq",      irq,      0);
    chk("rst_rd_count", rd_count, 0);
    rst_n = 1'b1;
    cyc(1);

    // Reset asserted mid-count clears everything at once
    cmd(0, OP_START, MODE_PERIODIC, 4);
    cyc(7);
    chk("pre_rst_running0", running[0], 1);
    chk("pre_rst_pending0", pending[0], 1);
    chk("pre_rst_irq",      irq,        1);
    chk("pre_rst_rd_count", rd_count,   1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_pending",  pending,  0);
    chk("async_rst_running",  running,  0);
    chk("async_rst_irq",      irq,      0);
    chk("async_rst_rd_count", rd_count, 0);
    cyc(1);
    rst_n = 1'b1;
    idle_hits = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (overflow != 2'b00 || running != 2'b00) idle_hits++;
    end
    chk("idle_100_quiet", idle_hits, 0);

    // Periodic P=4: pulses at 5, 10, 15
    cmd(0, OP_START, MODE_PERIODIC, 4);
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      chk($sformatf("p4_ovf0_k%0d", k), overflow[0], (k % 5) == 0);
      if (k == 4) chk("p4_pending_before", pending[0], 0);
      if (k == 5) chk("p4_pending_set",    pending[0], 1);
      if (k == 5) chk("p4_irq_lag",        irq,        0);
      if (k == 6) chk("p4_irq_set",        irq,        1);
    end

    // One-shot P=2 on ch1
    rd_ch = 1;
    cmd(1, OP_START, MODE_ONESHOT, 2);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk($sformatf("os_ovf1_k%0d", k), overflow[1], k == 3);
      if (k == 2) chk("os_running_mid",  running[1], 1);
      if (k == 3) chk("os_running_done", running[1], 0);
      if (k == 3) chk("os_rd_count_2",   rd_count,   2);
    end
    chk("os_rd_count_0", rd_count,   0);
    chk("os_pending1",   pending[1], 1);
    cmd(1, OP_CLEAR, MODE_PERIODIC, 0);
    chk("os_clear_pending1", pending[1], 0);

    // STOP on the wrap tick: no wrap, count holds
    cmd(1, OP_START, MODE_PERIODIC, 1);
    cyc(1);
    cmd(1, OP_STOP, MODE_PERIODIC, 0);
    chk("stopwrap_ovf1",     overflow[1], 0);
    chk("stopwrap_pending1", pending[1],  0);
    chk("stopwrap_running1", running[1],  0);
    cyc(1);
    chk("stopwrap_count1",   rd_count,    1);

    // STOP ch0 at count 2, count holds
    rd_ch = 0;
    cmd(0, OP_START, MODE_PERIODIC, 4);
    cyc(2);
    cmd(0, OP_STOP, MODE_PERIODIC, 0);
    cyc(10);
    chk("stop_rd_count2", rd_count,   2);
    chk("stop_running0",  running[0], 0);
    chk("stop_pending0",  pending[0], 1);

    // Period 0 overflows on every tick
    cmd(0, OP_START, MODE_PERIODIC, 0);
    chk("p0_start_no_ovf", overflow[0], 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("p0_ovf0_k%0d", k), overflow[0], 1);
    end

    // CLEAR in a wrap cycle: set wins
    cmd(0, OP_CLEAR, MODE_PERIODIC, 0);
    chk("clrwrap_pending0", pending[0],  1);
    chk("clrwrap_ovf0",     overflow[0], 1);
    cmd(0, OP_STOP, MODE_PERIODIC, 0);
    cmd(0, OP_CLEAR, MODE_PERIODIC, 0);
    chk("clr_pending0", pending[0], 0);
    cyc(1);
    chk("clr_irq", irq, 0);

    // START in the wrap cycle: no pulse, next pulse P+1 later
    cmd(0, OP_START, MODE_PERIODIC, 3);
    cyc(3);
    cmd(0, OP_START, MODE_PERIODIC, 3);
    chk("startwrap_ovf0",     overflow[0], 0);
    chk("startwrap_pending0", pending[0],  0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("startwrap_ovf0_k%0d", k), overflow[0], k == 4);
    end

    // PRESCALE=3, P=1: pulse every 8 cycles with ch1 traffic alongside
    p3_cmd_valid = 1'b1; p3_cmd_ch = 0; p3_cmd_op = OP_START;
    p3_cmd_mode = MODE_PERIODIC; p3_cmd_period = 1;
    cyc(1);
    np = 0;
    for (int c = 1; c <= 40; c++) begin
      p3_cmd_valid = 1'b0; p3_cmd_op = OP_NOP; p3_cmd_ch = 1;
      if (c == 2)  begin p3_cmd_valid = 1'b1; p3_cmd_op = OP_START; p3_cmd_mode = MODE_ONESHOT;  p3_cmd_period = 0; end
      if (c == 9)  begin p3_cmd_valid = 1'b1; p3_cmd_op = OP_START; p3_cmd_mode = MODE_PERIODIC; p3_cmd_period = 2; end
      if (c == 17) begin p3_cmd_valid = 1'b1; p3_cmd_op = OP_STOP;  end
      if (c == 25) begin p3_cmd_valid = 1'b1; p3_cmd_op = OP_CLEAR; end
      if (c == 30) begin p3_cmd_valid = 1'b1; p3_cmd_op = OP_START; p3_cmd_mode = MODE_PERIODIC; p3_cmd_period = 5; end
      cyc(1);
      if (p3_overflow[0] && np < 8) begin
        pulses[np] = c;
        np++;
      end
    end
    p3_cmd_valid = 1'b0;
    chk("p3_pulse_count", np, 5);
    if (np >= 1) chk("p3_first_in_range", (pulses[0] >= 5 && pulses[0] <= 8), 1);
    for (int i = 1; i < 5; i++) begin
      if (i < np) chk($sformatf("p3_gap%0d", i), pulses[i] - pulses[i-1], 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
